// File: rtl/mode_apply_ctrl_if.sv
// Configuration channel between mode_apply_ctrl and the video pipeline.
//   cfg_mode  : mode offered to the pipeline, stable while cfg_valid=1
//   cfg_valid : offer is present
//   cfg_ready : pipeline accepts; transfer on cfg_valid & cfg_ready
// master = mode_apply_ctrl side, slave = pipeline side.
interface mode_apply_ctrl_if #(
  parameter int MODE_BITS = 5
);
  logic [MODE_BITS-1:0] cfg_mode;
  logic                 cfg_valid;
  logic                 cfg_ready;

  modport master (output cfg_mode, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_mode, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/mode_apply_ctrl.sv
// Frame-synchronous mode scheduler. Filters out-of-range mode requests,
// waits for a vsync rising edge, then offers the mode to the pipeline over
// a valid/ready handshake with a timeout. After a successful transfer it
// holds off until the next frame edge, so the mode changes at most once per
// frame and never mid-frame.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_mode     : raw requested mode (may hold out-of-range values)
//   vsync        : frame sync, synchronous to clk
//   cfg          : configuration channel (master modport)
//   active_mode  : last mode accepted by the pipeline
//   busy         : FSM not in IDLE (registered)
//   err_timeout  : one-cycle pulse when a handshake is abandoned
module mode_apply_ctrl #(
  parameter int MODE_BITS = 5,
  parameter int NUM_MODES = 20,
  parameter int TO_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MODE_BITS-1:0] req_mode,
  input  logic                 vsync,
  mode_apply_ctrl_if.master    cfg,
  output logic [MODE_BITS-1:0] active_mode,
  output logic                 busy,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {IDLE, ARMED, SEND, HOLD} state_t;

  localparam logic [MODE_BITS:0] LIMIT   = (MODE_BITS+1)'(NUM_MODES);
  // Last counter value before giving up: the handshake is abandoned on the
  // 2^TO_BITS-th SEND cycle without ready, so err_timeout lands at M+2^TO_BITS.
  localparam logic [TO_BITS-1:0] TO_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};

  state_t               state, state_n;
  logic                 vsync_d;
  logic                 vs_edge, legal, differs;
  logic [MODE_BITS-1:0] pend, pend_n;
  logic [MODE_BITS-1:0] mode_q, mode_n;
  logic [MODE_BITS-1:0] active_n;
  logic [TO_BITS-1:0]   cnt, cnt_n;
  logic                 valid_q;
  logic                 err_n;

  assign vs_edge       = vsync & ~vsync_d;
  assign legal         = {1'b0, req_mode} < LIMIT;
  assign differs       = req_mode != active_mode;
  assign cfg.cfg_mode  = mode_q;
  assign cfg.cfg_valid = valid_q;

  always_comb begin
    state_n  = state;
    pend_n   = pend;
    mode_n   = mode_q;
    active_n = active_mode;
    cnt_n    = cnt;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        // An edge seen here is deliberately dropped; a request arriving with
        // it waits for the next edge.
        if (legal && differs) begin
          pend_n  = req_mode;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (legal && differs) pend_n = req_mode;
        if (!differs) begin
          state_n = IDLE;               // request cancelled
        end else if (vs_edge) begin
          mode_n  = pend;               // pend as registered at the edge
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (cfg.cfg_ready) begin
          active_n = mode_q;
          state_n  = HOLD;
        end else if (cnt == TO_LAST) begin
          // Give up; still-pending request re-arms from IDLE.
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (vs_edge) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vsync_d     <= 1'b1;   // no false edge if vsync is high through reset
      pend        <= '0;
      mode_q      <= '0;
      active_mode <= '0;
      cnt         <= '0;
      valid_q     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      vsync_d     <= vsync;
      pend        <= pend_n;
      mode_q      <= mode_n;
      active_mode <= active_n;
      cnt         <= cnt_n;
      valid_q     <= (state_n == SEND);
      busy        <= (state_n != IDLE);
      err_timeout <= err_n;
    end
  end

endmodule

// File: tb/tb_mode_apply_ctrl.sv
module tb_mode_apply_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req_mode;
  logic       vsync;
  logic [4:0] active_mode;
  logic       busy, err_timeout;
  int         errors = 0;
  int         checks = 0;

  mode_apply_ctrl_if #(.MODE_BITS(5)) cfg_if ();

  mode_apply_ctrl #(.MODE_BITS(5), .NUM_MODES(20), .TO_BITS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_mode    (req_mode),
    .vsync       (vsync),
    .cfg         (cfg_if),
    .active_mode (active_mode),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_vs();
    vsync = 1'b1; step();
    vsync = 1'b0; step();
  endtask

  initial begin
    // reset with vsync held high
    rst = 1'b1; vsync = 1'b1; req_mode = 5'd0; cfg_if.cfg_ready = 1'b1;
    step(); step();
    chk("rst_valid", 32'(cfg_if.cfg_valid), 0);
    chk("rst_mode", 32'(cfg_if.cfg_mode), 0);
    chk("rst_active", 32'(active_mode), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b0; step(); step();
    chk("rel_valid", 32'(cfg_if.cfg_valid), 0);
    chk("rel_busy", 32'(busy), 0);

    // basic request 3
    vsync = 1'b0; req_mode = 5'd3; step();
    chk("t1_armed", 32'(busy), 1);
    step();
    chk("t1_noedge_valid", 32'(cfg_if.cfg_valid), 0);
    vsync = 1'b1; step();
    chk("t1_valid", 32'(cfg_if.cfg_valid), 1);
    chk("t1_mode", 32'(cfg_if.cfg_mode), 3);
    chk("t1_active_pre", 32'(active_mode), 0);
    vsync = 1'b0; step();
    chk("t1_valid_drop", 32'(cfg_if.cfg_valid), 0);
    chk("t1_active", 32'(active_mode), 3);
    chk("t1_hold_busy", 32'(busy), 1);
    pulse_vs();
    chk("t1_idle", 32'(busy), 0);

    // illegal requests
    req_mode = 5'd31; step(); step();
    chk("t2_31_busy", 32'(busy), 0);
    pulse_vs();
    chk("t2_31_valid", 32'(cfg_if.cfg_valid), 0);
    chk("t2_31_active", 32'(active_mode), 3);
    req_mode = 5'd25; step();
    chk("t2_25_busy", 32'(busy), 0);
    pulse_vs();
    chk("t2_25_active", 32'(active_mode), 3);
    chk("t2_25_busy2", 32'(busy), 0);

    // last request before edge wins; next waits past HOLD
    req_mode = 5'd4; step();
    chk("t3_armed", 32'(busy), 1);
    req_mode = 5'd5; step();
    req_mode = 5'd6; step();
    vsync = 1'b1; step();
    chk("t3_valid", 32'(cfg_if.cfg_valid), 1);
    chk("t3_mode", 32'(cfg_if.cfg_mode), 6);
    vsync = 1'b0; req_mode = 5'd7; step();
    chk("t3_active6", 32'(active_mode), 6);
    chk("t3_valid_drop", 32'(cfg_if.cfg_valid), 0);
    step();
    vsync = 1'b1; step();          // edge ends HOLD
    chk("t3_hold_end_valid", 32'(cfg_if.cfg_valid), 0);
    step();                        // re-armed with 7
    vsync = 1'b0; step();
    chk("t3_armed7", 32'(busy), 1);
    chk("t3_wait_valid", 32'(cfg_if.cfg_valid), 0);
    vsync = 1'b1; step();
    chk("t3_valid7", 32'(cfg_if.cfg_valid), 1);
    chk("t3_mode7", 32'(cfg_if.cfg_mode), 7);
    vsync = 1'b0; step();
    chk("t3_active7", 32'(active_mode), 7);
    pulse_vs();
    chk("t3_idle", 32'(busy), 0);

    // timeout with TO_BITS=4
    cfg_if.cfg_ready = 1'b0; req_mode = 5'd9; step();
    vsync = 1'b1; step();          // M+1
    chk("t4_valid", 32'(cfg_if.cfg_valid), 1);
    vsync = 1'b0;
    for (int i = 0; i < 14; i++) step();   // M+15
    chk("t4_valid_m15", 32'(cfg_if.cfg_valid), 1);
    chk("t4_err_m15", 32'(err_timeout), 0);
    step();                        // M+16
    chk("t4_err", 32'(err_timeout), 1);
    chk("t4_valid_drop", 32'(cfg_if.cfg_valid), 0);
    chk("t4_active", 32'(active_mode), 7);
    chk("t4_idle", 32'(busy), 0);
    step();
    chk("t4_err_pulse", 32'(err_timeout), 0);
    chk("t4_rearm", 32'(busy), 1);
    cfg_if.cfg_ready = 1'b1;
    vsync = 1'b1; step();
    chk("t4_retry_valid", 32'(cfg_if.cfg_valid), 1);
    chk("t4_retry_mode", 32'(cfg_if.cfg_mode), 9);
    vsync = 1'b0; step();
    chk("t4_retry_active", 32'(active_mode), 9);
    pulse_vs();

    // cancel: return to active value before edge
    req_mode = 5'd8; step();
    chk("t5_armed", 32'(busy), 1);
    req_mode = 5'd9; step();
    chk("t5_cancel", 32'(busy), 0);
    vsync = 1'b1; step();          // edge in IDLE, forgotten
    chk("t5_valid", 32'(cfg_if.cfg_valid), 0);
    req_mode = 5'd10; step();      // vsync still high: no new edge
    chk("t5_armed10", 32'(busy), 1);
    step();
    chk("t5_no_stale_edge", 32'(cfg_if.cfg_valid), 0);
    vsync = 1'b0; step();
    vsync = 1'b1; step();
    chk("t5_mode10", 32'(cfg_if.cfg_mode), 10);
    vsync = 1'b0; step();
    chk("t5_active10", 32'(active_mode), 10);
    pulse_vs();

    // reset during SEND
    cfg_if.cfg_ready = 1'b0; req_mode = 5'd12; step();
    vsync = 1'b1; step();
    chk("t6_valid", 32'(cfg_if.cfg_valid), 1);
    rst = 1'b1; step();
    chk("t6_rst_valid", 32'(cfg_if.cfg_valid), 0);
    chk("t6_rst_active", 32'(active_mode), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    rst = 1'b0; step();            // vsync still high: no false edge
    step();
    chk("t6_no_false_edge", 32'(cfg_if.cfg_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
